// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment type and active-low glyph table for the display driver
// Contents: seg_t (segments a..g, index 0 = a) and GLYPH_* constants, 0 = segment lit.
package seg_pkg;

  typedef logic [0:6] seg_t;

  localparam seg_t GLYPH_0   = 7'b0000001;
  localparam seg_t GLYPH_1   = 7'b1001111;
  localparam seg_t GLYPH_2   = 7'b0010010;
  localparam seg_t GLYPH_3   = 7'b0000110;
  localparam seg_t GLYPH_4   = 7'b1001100;
  localparam seg_t GLYPH_5   = 7'b0100100;
  localparam seg_t GLYPH_6   = 7'b0100000;
  localparam seg_t GLYPH_7   = 7'b0001111;
  localparam seg_t GLYPH_8   = 7'b0000000;
  localparam seg_t GLYPH_9   = 7'b0000100;
  localparam seg_t GLYPH_A   = 7'b0001000;
  localparam seg_t GLYPH_B   = 7'b1100000;
  localparam seg_t GLYPH_C   = 7'b0110001;
  localparam seg_t GLYPH_D   = 7'b1000010;
  localparam seg_t GLYPH_E   = 7'b0110000;
  localparam seg_t GLYPH_F   = 7'b0111000;
  localparam seg_t GLYPH_ERR = 7'b1001000;
  localparam seg_t GLYPH_OFF = 7'b1111111;

endpackage

// File: rtl/seg_decoder.sv
// rtl/seg_decoder.sv - combinational 4-bit code to seven-segment glyph decoder
// Ports: code (4-bit digit code) -> seg (active-low a..g).
// HEX_MODE=1 shows A..F for codes 10..15, otherwise those codes show GLYPH_ERR.
module seg_decoder
  import seg_pkg::*;
#(
  parameter int HEX_MODE = 0
) (
  input  logic [3:0] code,
  output seg_t       seg
);

  localparam bit HEX = (HEX_MODE != 0);

  always_comb begin
    seg = GLYPH_ERR;
    case (code)
      4'd0:  seg = GLYPH_0;
      4'd1:  seg = GLYPH_1;
      4'd2:  seg = GLYPH_2;
      4'd3:  seg = GLYPH_3;
      4'd4:  seg = GLYPH_4;
      4'd5:  seg = GLYPH_5;
      4'd6:  seg = GLYPH_6;
      4'd7:  seg = GLYPH_7;
      4'd8:  seg = GLYPH_8;
      4'd9:  seg = GLYPH_9;
      4'd10: seg = HEX ? GLYPH_A : GLYPH_ERR;
      4'd11: seg = HEX ? GLYPH_B : GLYPH_ERR;
      4'd12: seg = HEX ? GLYPH_C : GLYPH_ERR;
      4'd13: seg = HEX ? GLYPH_D : GLYPH_ERR;
      4'd14: seg = HEX ? GLYPH_E : GLYPH_ERR;
      4'd15: seg = HEX ? GLYPH_F : GLYPH_ERR;
      default: seg = GLYPH_ERR;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed common-anode seven-segment scan driver
// Ports: clk, rst (async, active-high), en (0 = all dark), digits (4 bits per digit),
//        dp_in / blank / blink (one bit per digit), segments (a..g, active-low),
//        dp (active-low), anode_active (one-cold), slot_tick (pulse when a slot begins).
// All outputs are registered on the same edge so anode and segments never disagree.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 250000,
  parameter int BLINK_SLOTS = 200,
  parameter int HEX_MODE    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink,
  output seg_t                    segments,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode_active,
  output logic                    slot_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = $clog2(BLINK_SLOTS + 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = '1;

  logic [PRE_W-1:0] pre_cnt;
  logic [IDX_W-1:0] idx;
  logic [BLK_W-1:0] blk_cnt;
  logic             phase;
  logic             tick;
  logic             phase_new;
  logic             dark;
  logic [3:0]       code;
  seg_t             glyph;

  assign tick = (pre_cnt == PRE_W'(REFRESH_DIV - 1));

  // idx names the digit shown by the coming slot. blk_cnt counts slots already
  // shown in the current phase, so the toggle lands on the slot that starts
  // the new half-period rather than one slot late.
  assign phase_new = (blk_cnt == BLK_W'(BLINK_SLOTS)) ? ~phase : phase;
  assign code      = digits[{idx, 2'b00} +: 4];
  assign dark      = ~en | blank[idx] | (blink[idx] & phase_new);

  seg_decoder #(.HEX_MODE(HEX_MODE)) u_dec (
    .code (code),
    .seg  (glyph)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      idx     <= '0;
      blk_cnt <= '0;
      phase   <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) begin
        idx     <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        blk_cnt <= (blk_cnt == BLK_W'(BLINK_SLOTS)) ? BLK_W'(1) : blk_cnt + 1'b1;
        phase   <= phase_new;
      end
    end
  end

  // Inputs are sampled only on the tick; en=0 additionally forces dark on
  // any edge so the display blanks without waiting for the slot to end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      segments     <= GLYPH_OFF;
      dp           <= 1'b1;
      anode_active <= ANODE_OFF;
      slot_tick    <= 1'b0;
    end else begin
      slot_tick <= tick;
      if (tick) begin
        if (dark) begin
          segments     <= GLYPH_OFF;
          dp           <= 1'b1;
          anode_active <= ANODE_OFF;
        end else begin
          segments     <= glyph;
          dp           <= ~dp_in[idx];
          anode_active <= ~(NUM_DIGITS'(1) << idx);
        end
      end else if (!en) begin
        segments     <= GLYPH_OFF;
        dp           <= 1'b1;
        anode_active <= ANODE_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver (two configurations)
module tb_seg_scan_driver;

  localparam int R = 4;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] dig;
  logic [7:0]  dp_in;
  logic [7:0]  blank;
  logic [7:0]  blink;

  logic [0:6]  seg_a, seg_b;
  logic        dp_a, dp_b, tick_a, tick_b;
  logic [3:0]  an_a;
  logic [5:0]  an_b;

  int checks = 0;
  int errors = 0;

  // Instance A: 4 digits, blink every 2 slots, decimal only.
  seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(R), .BLINK_SLOTS(2), .HEX_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .digits(dig[15:0]), .dp_in(dp_in[3:0]),
    .blank(blank[3:0]), .blink(blink[3:0]), .segments(seg_a), .dp(dp_a),
    .anode_active(an_a), .slot_tick(tick_a)
  );

  // Instance B: 6 digits (non-power-of-2), blink every 3 slots, hex glyphs.
  seg_scan_driver #(.NUM_DIGITS(6), .REFRESH_DIV(R), .BLINK_SLOTS(3), .HEX_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .digits(dig[23:0]), .dp_in(dp_in[5:0]),
    .blank(blank[5:0]), .blink(blink[5:0]), .segments(seg_b), .dp(dp_b),
    .anode_active(an_b), .slot_tick(tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: e = clk edges since reset release. Edge e starts slot
  // s = e/R - 1 whenever e is a positive multiple of R; that slot shows digit
  // s mod N with blink phase (s / BLINK_SLOTS) mod 2.
  int         e;
  logic [6:0] m_seg  [2];
  logic       m_dp   [2];
  logic [7:0] m_an   [2];
  logic       m_tick [2];

  function automatic logic [6:0] glyph(input logic [3:0] c, input bit hex);
    case (c)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      4'd10: return hex ? 7'b0001000 : 7'b1001000;
      4'd11: return hex ? 7'b1100000 : 7'b1001000;
      4'd12: return hex ? 7'b0110001 : 7'b1001000;
      4'd13: return hex ? 7'b1000010 : 7'b1001000;
      4'd14: return hex ? 7'b0110000 : 7'b1001000;
      default: return hex ? 7'b0111000 : 7'b1001000;
    endcase
  endfunction

  function automatic int ndig(input int i);
    return (i == 0) ? 4 : 6;
  endfunction

  task automatic set_dark(input int i);
    m_seg[i] = 7'h7f;
    m_dp[i]  = 1'b1;
    m_an[i]  = 8'((1 << ndig(i)) - 1);
  endtask

  task automatic model_reset();
    e = 0;
    for (int i = 0; i < 2; i++) begin
      set_dark(i);
      m_tick[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int s, idx, bs, ph;
    for (int i = 0; i < 2; i++) begin
      bs = (i == 0) ? 2 : 3;
      m_tick[i] = (e % R == 0) && (e > 0);
      if (m_tick[i]) begin
        s   = e / R - 1;
        idx = s % ndig(i);
        ph  = (s / bs) % 2;
        if (!en || blank[idx] || (blink[idx] && ph == 1)) begin
          set_dark(i);
        end else begin
          m_seg[i] = glyph(dig[4*idx +: 4], i == 1);
          m_dp[i]  = ~dp_in[idx];
          m_an[i]  = 8'((1 << ndig(i)) - 1) & ~(8'd1 << idx);
        end
      end else if (!en) begin
        set_dark(i);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic compare_all();
    check("seg_a",  32'(seg_a),  32'(m_seg[0]));
    check("dp_a",   32'(dp_a),   32'(m_dp[0]));
    check("an_a",   32'(an_a),   32'(m_an[0]));
    check("tick_a", 32'(tick_a), 32'(m_tick[0]));
    check("seg_b",  32'(seg_b),  32'(m_seg[1]));
    check("dp_b",   32'(dp_b),   32'(m_dp[1]));
    check("an_b",   32'(an_b),   32'(m_an[1]));
    check("tick_b", 32'(tick_b), 32'(m_tick[1]));
  endtask

  // Inputs only change at the negative edge, so they are stable across the
  // positive edge that the model evaluates.
  task automatic step();
    @(posedge clk);
    e++;
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    dig   = 32'h0065_4321;
    dp_in = 8'h00;
    blank = 8'h00;
    blink = 8'h00;
    model_reset();

    // Reset state
    #12;
    compare_all();
    check("rst_an_a", 32'(an_a), 32'h0000_000f);
    check("rst_seg_a", 32'(seg_a), 32'h0000_007f);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Scan order: first tick after R edges drives digit 0 of 4321
    for (int k = 0; k < 4; k++) step();
    check("first_an_a", 32'(an_a), 32'b1110);
    check("first_seg_a", 32'(seg_a), 32'b1001111);
    check("first_tick_a", 32'(tick_a), 32'd1);
    step();
    check("tick_one_cycle", 32'(tick_a), 32'd0);
    while (e < 8) step();
    check("second_an_a", 32'(an_a), 32'b1101);
    check("second_seg_a", 32'(seg_a), 32'b0010010);

    // Non-power-of-2 wrap on the six-digit instance
    while (e < 24) step();
    check("wrap_last_an_b", 32'(an_b), 32'b011111);
    while (e < 28) step();
    check("wrap_first_an_b", 32'(an_b), 32'b111110);

    // Glyph mode and decimal point: code B on digit 0 (slot 12 = digit 0 on both)
    dig[3:0] = 4'hB;
    dp_in    = 8'h01;
    while (e < 52) step();
    check("glyph_err_a", 32'(seg_a), 32'b1001000);
    check("glyph_hex_b", 32'(seg_b), 32'b1100000);
    check("dp_lit_a", 32'(dp_a), 32'd0);

    // Blink and blank over several blink periods
    dig   = 32'h0065_4321;
    dp_in = 8'h00;
    blink = 8'b0010;
    blank = 8'b1000;
    for (int k = 0; k < 96; k++) step();

    // Enable dropped mid-slot, raised again
    blink = 8'h00;
    blank = 8'h00;
    while (e % R != 1) step();
    en = 1'b0;
    step();
    check("en_off_an_a", 32'(an_a), 32'h0000_000f);
    check("en_off_seg_b", 32'(seg_b), 32'h0000_007f);
    en = 1'b1;
    step();
    check("en_mid_dark_a", 32'(an_a), 32'h0000_000f);
    while (e % R != 0) step();
    check("en_back_lit_a", 32'($countones(~an_a)), 32'd1);

    // Asynchronous reset mid-slot, then digit 0 again with phase 0
    blink = 8'h01;
    step();
    #2 rst = 1'b1;
    #1;
    check("arst_an_a", 32'(an_a), 32'h0000_000f);
    check("arst_an_b", 32'(an_b), 32'h0000_003f);
    check("arst_seg_a", 32'(seg_a), 32'h0000_007f);
    check("arst_dp_b", 32'(dp_b), 32'd1);
    #1 rst = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) step();
    check("arst_wait_an_a", 32'(an_a), 32'h0000_000f);
    step();
    check("arst_d0_an_a", 32'(an_a), 32'b1110);
    check("arst_d0_an_b", 32'(an_b), 32'b111110);
    check("arst_d0_seg_a", 32'(seg_a), 32'b1001111);

    // Randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        dig   = $urandom;
        dp_in = 8'($urandom);
        blank = 8'($urandom & $urandom & $urandom);
        blink = 8'($urandom);
      end
      en = ($urandom_range(0, 15) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
